sr_nor_latch: RTL and testbench

- Clocked model of a cross-coupled NOR SR latch bank, with WIDTH independent cells.
- Each cell has set/reset inputs and complementary outputs. S=R=1 is a forbidden input and is flagged.
- Used as a registered set/reset status element; it sits between control logic and consumers that need both Q and Qn.
- Adds forbidden-input detection: a sticky error flag and a saturating event counter.

---
 rtl/sr_nor_latch.sv | 178 +++++++++++++++++
 tb/tb_sr_nor_latch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sr_nor_latch.sv
// rtl/sr_nor_latch.sv - registered bank of NOR SR latch cells with forbidden-input tracking

// Single SR cell.
// Cross-coupled NOR behaviour is modelled as registered next-state logic.
// A cell leaving the both-low forbidden state resolves reset-dominant.
module sr_nor_latch_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qn,
  output logic invalid
);

  logic q_q, q_d;
  logic qn_q, qn_d;
  logic inv_q, inv_d;

  // Next state of one cell from the sampled set/reset pair
  always_comb begin
    q_d   = q_q;
    qn_d  = qn_q;
    inv_d = 1'b0;
    case ({s, r})
      2'b11: begin
        // Both NOR outputs are driven low while set and reset are both high
        q_d   = 1'b0;
        qn_d  = 1'b0;
        inv_d = 1'b1;
      end
      2'b10: begin
        q_d  = 1'b1;
        qn_d = 1'b0;
      end
      2'b01: begin
        q_d  = 1'b0;
        qn_d = 1'b1;
      end
      default: begin
        // Hold the current state, unless the outputs are not complementary.
        // That happens after a forbidden input. A real latch would race here,
        // so the model settles on the reset state instead.
        if (q_q == qn_q) begin
          q_d  = 1'b0;
          qn_d = 1'b1;
        end
      end
    endcase
  end

  // Cell state register with asynchronous reset to the cleared state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= 1'b0;
      qn_q  <= 1'b1;
      inv_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      qn_q  <= qn_d;
      inv_q <= inv_d;
    end
  end

  assign q       = q_q;
  assign qn      = qn_q;
  assign invalid = inv_q;

endmodule

// Saturating event counter with synchronous clear.
// When a clear and an event arrive on the same edge, the count restarts at one.
module sr_nor_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] base;

  // Apply the clear first, then add the event if there is headroom
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc && (base != '1)) begin
      cnt_d = base + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// Top level: WIDTH independent cells.
// Also keeps a sticky error flag and a per-edge count of forbidden inputs.
module sr_nor_latch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic any_illegal;
  logic err_q, err_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_nor_latch_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .qn      (qn[i]),
      .invalid (invalid[i])
    );
  end

  // One event per edge, however many cells see set and reset together
  always_comb begin
    any_illegal = |(s & r);
  end

  // Sticky error flag; a new forbidden input overrides a clear on the same edge
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (any_illegal) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  sr_nor_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_err),
    .inc (any_illegal),
    .cnt (illegal_cnt)
  );

  assign err_sticky = err_q;

endmodule

// File: tb/tb_sr_nor_latch.sv
// tb/tb_sr_nor_latch.sv - scoreboard bench for sr_nor_latch with a 4-cell bank

module tb_sr_nor_latch;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;
  logic [3:0] q;
  logic [3:0] qn;
  logic [3:0] invalid;
  logic       err_sticky;
  logic [7:0] illegal_cnt;

  typedef struct {
    logic [3:0] q;
    logic [3:0] qn;
    logic [3:0] inv;
    logic       err;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  sr_nor_latch #(
    .WIDTH (4),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s),
    .r           (r),
    .clr_err     (clr_err),
    .q           (q),
    .qn          (qn),
    .invalid     (invalid),
    .err_sticky  (err_sticky),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge and queue what the next rising edge must produce
  task automatic apply(input logic rst_v, input logic [3:0] s_v, input logic [3:0] r_v,
                       input logic clr_v, input logic [3:0] eq, input logic [3:0] eqn,
                       input logic [3:0] einv, input logic eerr, input logic [7:0] ecnt,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst     = rst_v;
    s       = s_v;
    r       = r_v;
    clr_err = clr_v;
    e.q = eq; e.qn = eqn; e.inv = einv; e.err = eerr; e.cnt = ecnt; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: after every rising clock or rising reset, compare against the oldest expectation
  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (q !== e.q) begin
          miscompares++;
          $display("FAIL %s q: got %b want %b", e.name, q, e.q);
        end
        if (qn !== e.qn) begin
          miscompares++;
          $display("FAIL %s qn: got %b want %b", e.name, qn, e.qn);
        end
        if (invalid !== e.inv) begin
          miscompares++;
          $display("FAIL %s invalid: got %b want %b", e.name, invalid, e.inv);
        end
        if (err_sticky !== e.err) begin
          miscompares++;
          $display("FAIL %s err_sticky: got %b want %b", e.name, err_sticky, e.err);
        end
        if (illegal_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s illegal_cnt: got %0d want %0d", e.name, illegal_cnt, e.cnt);
        end
      end
    end
  end

  // Directed stimulus; single-cell cases use bit 0 and leave the other cells in reset state
  initial begin
    exp_t ar;
    int   exp_cnt;
    rst     = 1'b1;
    s       = 4'b0000;
    r       = 4'b0000;
    clr_err = 1'b0;

    // Reset held, then released with idle inputs
    apply(1, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "reset_a");
    apply(1, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "reset_b");
    apply(0, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "idle_a");
    apply(0, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "idle_b");

    // Set, then hold for three edges
    apply(0, 4'h1, 4'h0, 0, 4'h1, 4'hE, 4'h0, 0, 8'd0, "set");
    for (int i = 0; i < 3; i++)
      apply(0, 4'h0, 4'h0, 0, 4'h1, 4'hE, 4'h0, 0, 8'd0, "hold_set");

    // Reset / set / reset, one edge each
    apply(0, 4'h0, 4'h1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "rst_in_a");
    apply(0, 4'h1, 4'h0, 0, 4'h1, 4'hE, 4'h0, 0, 8'd0, "set_in");
    apply(0, 4'h0, 4'h1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "rst_in_b");

    // Forbidden input, then set out of it
    apply(0, 4'h1, 4'h1, 0, 4'h0, 4'hE, 4'h1, 1, 8'd1, "forbid_a");
    apply(0, 4'h1, 4'h0, 0, 4'h1, 4'hE, 4'h0, 1, 8'd1, "set_after_forbid");

    // Forbidden, then release with idle inputs resolves reset-dominant
    apply(0, 4'h1, 4'h1, 0, 4'h0, 4'hE, 4'h1, 1, 8'd2, "forbid_b");
    apply(0, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1, 8'd2, "release");

    // 300 forbidden edges: counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      exp_cnt = (2 + i > 255) ? 255 : 2 + i;
      apply(0, 4'h1, 4'h1, 0, 4'h0, 4'hE, 4'h1, 1, 8'(exp_cnt), "saturate");
    end

    // Clear with idle inputs
    apply(0, 4'h0, 4'h0, 1, 4'h0, 4'hF, 4'h0, 0, 8'd0, "clr");

    // Clear on the same edge as a forbidden input: the forbidden input wins
    apply(0, 4'h1, 4'h1, 0, 4'h0, 4'hE, 4'h1, 1, 8'd1, "forbid_c");
    apply(0, 4'h1, 4'h1, 0, 4'h0, 4'hE, 4'h1, 1, 8'd2, "forbid_d");
    apply(0, 4'h1, 4'h1, 1, 4'h0, 4'hE, 4'h1, 1, 8'd1, "clr_vs_forbid");

    // Clear leaves the latch state alone
    apply(0, 4'h1, 4'h0, 1, 4'h1, 4'hE, 4'h0, 0, 8'd0, "clr_keeps_q");

    // Asynchronous reset between edges while q=1
    @(negedge clk);
    ar.q = 4'h0; ar.qn = 4'hF; ar.inv = 4'h0; ar.err = 1'b0; ar.cnt = 8'd0; ar.name = "async_rst";
    s = 4'h0;
    clr_err = 1'b0;
    sb.push_back(ar);
    rst = 1'b1;
    apply(1, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, "rst_hold");

    // Multi-cell vector straight after reset release
    apply(0, 4'b0101, 4'b0011, 0, 4'b0100, 4'b1010, 4'b0001, 1, 8'd1, "multi");
    apply(0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'hF, 1, 8'd2, "all_forbid");
    apply(0, 4'h0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 1, 8'd2, "all_release");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
